// File: rtl/fft_pkg.sv
// fft_pkg: shared types and helpers
// for the FFT datapath blocks.
package fft_pkg;

  localparam int CPLX_DW = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  function automatic logic [CPLX_DW-1:0] cplx_re(
    input logic [2*CPLX_DW-1:0] c
  );
    return c[2*CPLX_DW-1:CPLX_DW];
  endfunction

  function automatic logic [CPLX_DW-1:0] cplx_im(
    input logic [2*CPLX_DW-1:0] c
  );
    return c[CPLX_DW-1:0];
  endfunction

  function automatic logic [2*CPLX_DW-1:0] cplx_pack(
    input logic [CPLX_DW-1:0] re,
    input logic [CPLX_DW-1:0] im
  );
    return {re, im};
  endfunction

  function automatic bit max_delay_ok(input int m);
    return (m >= 1) && ((m & (m - 1)) == 0);
  endfunction

endpackage

// File: rtl/var_delay_line.sv
// var_delay_line: step-enabled circular buffer
// whose length is 2^dlog, up to MAX_DELAY.
module var_delay_line
  import fft_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MAX_DELAY = 64,
  parameter int LOG2W     = 3,
  parameter bit CLEAR     = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [LOG2W-1:0] dlog,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int AW =
    (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;

  logic [WIDTH-1:0] mem [MAX_DELAY];
  logic [AW-1:0]    ptr;
  logic [AW-1:0]    last;

  assign last = AW'((1 << dlog) - 1);
  assign dout = mem[ptr];

  // pointer walks 0..D-1 once per step
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      ptr <= '0;
    else if (en)
      ptr <= (ptr == last) ? '0 : ptr + 1'b1;
  end

  if (CLEAR) begin : g_clr
    // cleared storage, used for the tag lane
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int i = 0; i < MAX_DELAY; i++)
          mem[i] <= '0;
      end else if (en) begin
        mem[ptr] <= din;
      end
    end
  end else begin : g_raw
    // plain storage for the data lanes
    always_ff @(posedge clk) begin
      if (en)
        mem[ptr] <= din;
    end
  end

endmodule

// File: rtl/param_delay_commutator.sv
// param_delay_commutator: radix-2 MDC delay
// commutator with a per-frame delay D.
module param_delay_commutator
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_DELAY  = 64,
  parameter int LOG2W =
    $clog2($clog2(MAX_DELAY) + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [2*DATA_WIDTH-1:0] x0,
  input  logic [2*DATA_WIDTH-1:0] x1,
  input  logic [LOG2W-1:0]        cfg_delay_log2,
  input  logic                    flush,
  output logic [2*DATA_WIDTH-1:0] y0,
  output logic [2*DATA_WIDTH-1:0] y1,
  output logic                    out_valid,
  output logic                    busy,
  output logic                    err
);

  localparam int CW     = 2 * DATA_WIDTH;
  localparam int MAXLOG = $clog2(MAX_DELAY);
  localparam int NW     = MAXLOG + 1;
  localparam logic [LOG2W-1:0] MAXL =
    LOG2W'(MAXLOG);

  if (!max_delay_ok(MAX_DELAY)) begin : g_bad
    $error("MAX_DELAY must be a power of two");
  end

  state_t state, state_nx;

  logic [LOG2W-1:0] dlog_q, cfg_c, eff;
  logic [NW-1:0]    n, n_inc, mask, dm1, selm;
  logic             acc, drn, step, sel;
  logic             flush_ok, err_nx;
  logic [CW-1:0]    in0, in1, a1, b0, b1, d0;
  logic             tag_d;

  // step qualification, counter math, lane switch
  always_comb begin
    cfg_c = (cfg_delay_log2 > MAXL) ?
            MAXL : cfg_delay_log2;
    eff   = (state == IDLE) ? cfg_c : dlog_q;
    mask  = NW'((2 << eff) - 1);
    dm1   = NW'((1 << eff) - 1);
    selm  = NW'(1) << eff;
    acc   = in_valid && (state != DRAIN);
    drn   = (state == DRAIN);
    step  = acc || drn;
    n_inc = (n + 1'b1) & mask;
    sel   = |(n & selm);
    in0   = drn ? '0 : x0;
    in1   = drn ? '0 : x1;
    b0    = sel ? a1 : in0;
    b1    = sel ? in0 : a1;
  end

  // next state; flush legal only on a block edge
  always_comb begin
    state_nx = state;
    flush_ok = flush && (state == RUN) &&
               ((step ? n_inc : n) == '0);
    unique case (state)
      IDLE:  if (in_valid) state_nx = RUN;
      RUN:   if (flush_ok) state_nx = DRAIN;
      DRAIN: if (n == dm1) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // status outputs and violation detect
  always_comb begin
    busy   = (state != IDLE);
    err_nx = (flush && !flush_ok) ||
             (in_valid && drn) ||
             ((state == IDLE) && in_valid &&
              (cfg_delay_log2 > MAXL));
  end

  // state, step count and latched delay
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      n      <= '0;
      dlog_q <= '0;
    end else begin
      state <= state_nx;
      if (state_nx == IDLE)
        n <= '0;
      else if (step)
        n <= n_inc;
      if ((state == IDLE) && in_valid)
        dlog_q <= cfg_c;
    end
  end

  // registered outputs; y holds on untagged steps
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y0        <= '0;
      y1        <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      out_valid <= step && tag_d;
      err       <= err_nx;
      if (step && tag_d) begin
        y0 <= d0;
        y1 <= b1;
      end
    end
  end

  var_delay_line #(
    .WIDTH(CW), .MAX_DELAY(MAX_DELAY),
    .LOG2W(LOG2W), .CLEAR(1'b0)
  ) u_lane1 (
    .clk(clk), .reset(reset), .en(step),
    .dlog(eff), .din(in1), .dout(a1)
  );

  var_delay_line #(
    .WIDTH(CW), .MAX_DELAY(MAX_DELAY),
    .LOG2W(LOG2W), .CLEAR(1'b0)
  ) u_lane0 (
    .clk(clk), .reset(reset), .en(step),
    .dlog(eff), .din(b0), .dout(d0)
  );

  var_delay_line #(
    .WIDTH(1), .MAX_DELAY(MAX_DELAY),
    .LOG2W(LOG2W), .CLEAR(1'b1)
  ) u_tag (
    .clk(clk), .reset(reset), .en(step),
    .dlog(eff), .din(acc), .dout(tag_d)
  );

endmodule
